// File: rtl/execute_md_pkg.sv
// Shared encodings for the EX stage multiply/divide slice.
// EXECUTE_MD_DIV_EN enables the DIVU/REMU encodings.
package execute_md_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIVU = 2'b10,
    MD_REMU = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Without the divider, 10/11 fall back to the plain ALU path.
  function automatic md_op_e md_op_eff(logic [1:0] op);
`ifdef EXECUTE_MD_DIV_EN
    return md_op_e'(op);
`else
    return (op == MD_MUL) ? MD_MUL : MD_NONE;
`endif
  endfunction

endpackage

// File: rtl/ALU.sv
// Integer ALU: and/or/add/sub/slt/nor.
// Purely combinational.
module ALU
  import execute_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ctl,
  output logic [XLEN-1:0] result
);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    unique case (ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ALU_CONTROL.sv
// ALU operation decoder: alu_op from EX control,
// funct from imm[5:0] for R-type.
module ALU_CONTROL
  import execute_md_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl
);

  logic [3:0] rtype;

  always_comb begin
    rtype = ALU_ADD;
    unique case (1'b1)
      (funct == 6'h20): rtype = ALU_ADD;
      (funct == 6'h22): rtype = ALU_SUB;
      (funct == 6'h24): rtype = ALU_AND;
      (funct == 6'h25): rtype = ALU_OR;
      (funct == 6'h27): rtype = ALU_NOR;
      (funct == 6'h2a): rtype = ALU_SLT;
      default:          rtype = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_ctl = ALU_ADD;
    unique case (alu_op)
      2'b00:   alu_ctl = ALU_ADD;
      2'b01:   alu_ctl = ALU_SUB;
      2'b10:   alu_ctl = rtype;
      default: alu_ctl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply / restoring divide, one bit per cycle.
// Divider datapath only present with EXECUTE_MD_DIV_EN.
module md_unit
  import execute_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  md_state_e       state;
  md_op_e          op_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] p;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] d;

`ifdef EXECUTE_MD_DIV_EN
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  assign rem_sh = {p, q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, d};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      op_q  <= MD_NONE;
      cnt   <= '0;
      p     <= '0;
      q     <= '0;
      d     <= '0;
    end else if (kill) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            op_q  <= op;
            cnt   <= '0;
            p     <= '0;
            // mul: q=multiplier, d=multiplicand
            // div: q=dividend,  d=divisor
            if (op == MD_MUL) begin
              q <= b;
              d <= a;
            end else begin
              q <= a;
              d <= b;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1))
            state <= ST_DONE;
          if (op_q == MD_MUL) begin
            if (q[0])
              p <= p + d;
            q <= q >> 1;
            d <= d << 1;
          end
`ifdef EXECUTE_MD_DIV_EN
          else if (!diff[XLEN]) begin
            p <= diff[XLEN-1:0];
            q <= {q[XLEN-2:0], 1'b1};
          end else begin
            p <= rem_sh[XLEN-1:0];
            q <= {q[XLEN-2:0], 1'b0};
          end
`endif
        end
        ST_DONE: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_comb begin
    result = p;
    if (op_q == MD_DIVU)
      result = q;
  end

endmodule

// File: rtl/execute_md.sv
// EX stage with forwarding, ALU and iterative mul/div unit.
// Define EXECUTE_MD_DIV_EN to build in DIVU/REMU.
module execute_md
  import execute_md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            flush,
  input  logic [1:0]      wb_in,
  input  logic [2:0]      m_in,
  input  logic [3:0]      ex_in,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] npc,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] imm,
  input  logic [REGW-1:0] rt,
  input  logic [REGW-1:0] rd,
  input  logic [1:0]      forward_a_sel,
  input  logic [1:0]      forward_b_sel,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] mem_alu_result,
  output logic            md_busy,
  output logic [1:0]      wb_ctlout,
  output logic [2:0]      m_ctlout,
  output logic [XLEN-1:0] add_result,
  output logic            zero,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] rdata2out,
  output logic [REGW-1:0] dest_out
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] md_res;
  logic [3:0]      alu_ctl;
  md_op_e          op_eff;
  logic            md_start;
  logic            md_run;
  logic            md_done;

  always_comb begin
    op_a = rdata1;
    unique case (forward_a_sel)
      FWD_WB:  op_a = wb_data;
      FWD_MEM: op_a = mem_alu_result;
      default: op_a = rdata1;
    endcase
  end

  always_comb begin
    op_b = rdata2;
    unique case (forward_b_sel)
      FWD_WB:  op_b = wb_data;
      FWD_MEM: op_b = mem_alu_result;
      default: op_b = rdata2;
    endcase
  end

  assign alu_b = ex_in[0] ? imm : op_b;

  ALU_CONTROL u_alu_ctl (
    .alu_op (ex_in[2:1]),
    .funct  (imm[5:0]),
    .alu_ctl(alu_ctl)
  );

  ALU #(.XLEN(XLEN)) u_alu (
    .a     (op_a),
    .b     (alu_b),
    .ctl   (alu_ctl),
    .result(alu_res)
  );

  assign op_eff   = md_op_eff(md_op);
  assign md_start = (op_eff != MD_NONE) && enable && !flush;

  md_unit #(.XLEN(XLEN)) u_md (
    .clk   (clk),
    .rst   (rst),
    .kill  (flush),
    .start (md_start),
    .op    (op_eff),
    .a     (op_a),
    .b     (op_b),
    .busy  (md_run),
    .done  (md_done),
    .result(md_res)
  );

  // Start is only honoured from IDLE, so DONE masks it.
  assign md_busy = rst & (md_run | (md_start & ~md_done));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ctlout  <= '0;
      m_ctlout   <= '0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2out  <= '0;
      dest_out   <= '0;
    end else if (flush || md_busy) begin
      wb_ctlout <= '0;
      m_ctlout  <= '0;
    end else if (enable) begin
      wb_ctlout  <= wb_in;
      m_ctlout   <= m_in;
      add_result <= npc + (imm << 2);
      rdata2out  <= op_b;
      dest_out   <= ex_in[3] ? rd : rt;
      if (md_done) begin
        alu_result <= md_res;
        zero       <= (md_res == '0);
      end else begin
        alu_result <= alu_res;
        zero       <= (alu_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_execute_md.sv
// Scoreboard bench for execute_md: stimulus pushes expectations,
// a monitor pops them whenever a new instruction lands in EX/MEM.
module tb_execute_md;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            flush;
  logic [1:0]      wb_in;
  logic [2:0]      m_in;
  logic [3:0]      ex_in;
  logic [1:0]      md_op;
  logic [XLEN-1:0] npc, rdata1, rdata2, imm;
  logic [REGW-1:0] rt, rd;
  logic [1:0]      forward_a_sel, forward_b_sel;
  logic [XLEN-1:0] wb_data, mem_alu_result;
  logic            md_busy;
  logic [1:0]      wb_ctlout;
  logic [2:0]      m_ctlout;
  logic [XLEN-1:0] add_result, alu_result, rdata2out;
  logic            zero;
  logic [REGW-1:0] dest_out;

  always #5 clk = ~clk;

  execute_md #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in), .md_op(md_op),
    .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .imm(imm),
    .rt(rt), .rd(rd),
    .forward_a_sel(forward_a_sel), .forward_b_sel(forward_b_sel),
    .wb_data(wb_data), .mem_alu_result(mem_alu_result),
    .md_busy(md_busy), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
    .add_result(add_result), .zero(zero), .alu_result(alu_result),
    .rdata2out(rdata2out), .dest_out(dest_out)
  );

  typedef struct {
    string       nm;
    logic [31:0] alu;
    logic [31:0] add;
    logic        z;
    logic [4:0]  dest;
    logic [31:0] r2;
    bit          r2_v;
    logic [1:0]  wb;
    logic [2:0]  m;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    else
      n_pass++;
  endtask

  task automatic set_in(
    input logic [1:0] w, input logic [2:0] mm,
    input logic [3:0] ex, input logic [1:0] op,
    input logic [31:0] pc, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] im,
    input logic [4:0] t, input logic [4:0] d,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic [31:0] wd, input logic [31:0] md);
    wb_in = w; m_in = mm; ex_in = ex; md_op = op;
    npc = pc; rdata1 = a; rdata2 = b; imm = im;
    rt = t; rd = d;
    forward_a_sel = fa; forward_b_sel = fb;
    wb_data = wd; mem_alu_result = md;
  endtask

  task automatic push(input string nm, input logic [31:0] alu,
                      input logic [31:0] add, input logic z,
                      input logic [4:0] dest, input logic [31:0] r2,
                      input bit r2_v);
    exp_t e;
    e.nm = nm; e.alu = alu; e.add = add; e.z = z;
    e.dest = dest; e.r2 = r2; e.r2_v = r2_v;
    e.wb = wb_in; e.m = m_in;
    sb.push_back(e);
  endtask

  task automatic bubble();
    wb_in = '0; m_in = '0; md_op = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input string nm);
    @(negedge clk);
    chk({nm, ".busy"}, md_busy, 0);
    step();
    bubble();
    step();
  endtask

  task automatic run_md(input string nm, input int exp_busy,
                        input bit scramble);
    int cnt = 0;
    bit bub_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!md_busy) break;
      cnt++;
      if (cnt > 1 && (wb_ctlout != 0 || m_ctlout != 0))
        bub_ok = 1'b0;
      if (scramble && cnt == 2) begin
        wb_data = 32'hdead_0001;
        mem_alu_result = 32'hbeef_0002;
      end
    end
    chk({nm, ".busy_cycles"}, cnt, exp_busy);
    chk({nm, ".stall_bubbles"}, {31'd0, bub_ok}, 1);
    step();
    bubble();
    step();
  endtask

  // Monitor: a rising wb_ctlout marks a fresh EX/MEM load.
  initial begin
    logic [1:0] prev = 2'b00;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && wb_ctlout != 0 && prev == 0) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_load: got alu %h wb %b, expected none",
                   alu_result, wb_ctlout);
        end else begin
          e = sb.pop_front();
          chk({e.nm, ".alu"}, alu_result, e.alu);
          chk({e.nm, ".zero"}, {31'd0, zero}, {31'd0, e.z});
          chk({e.nm, ".add"}, add_result, e.add);
          chk({e.nm, ".dest"}, {27'd0, dest_out}, {27'd0, e.dest});
          chk({e.nm, ".wb"}, {30'd0, wb_ctlout}, {30'd0, e.wb});
          chk({e.nm, ".m"}, {29'd0, m_ctlout}, {29'd0, e.m});
          if (e.r2_v)
            chk({e.nm, ".r2"}, rdata2out, e.r2);
        end
      end
      prev = wb_ctlout;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; enable = 1'b1; flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst.alu", alu_result, 0);
    chk("rst.add", add_result, 0);
    chk("rst.wb", {30'd0, wb_ctlout}, 0);
    chk("rst.busy", {31'd0, md_busy}, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // forwarded A from MEM: 9 + 1
    set_in(2'b10, 3'b001, 4'b1000, 2'b00, 32'h100, 32'd123, 32'd1,
           32'd4, 5'd3, 5'd7, 2'b10, 2'b00, 32'd0, 32'd9);
    push("fwd_mem_add", 32'd10, 32'h110, 1'b0, 5'd7, 32'd1, 1);
    run_alu("fwd_mem_add");

    // forwarded B from WB: 5 - 20
    set_in(2'b01, 3'b010, 4'b0010, 2'b00, 32'h200, 32'd5, 32'd77,
           32'd1, 5'd4, 5'd9, 2'b00, 2'b01, 32'd20, 32'd0);
    push("fwd_wb_sub", 32'hffff_fff1, 32'h204, 1'b0, 5'd4, 32'd20, 1);
    run_alu("fwd_wb_sub");

    // select 11 behaves as register path, 9 - 9 = 0
    set_in(2'b11, 3'b100, 4'b0010, 2'b00, 32'h300, 32'd9, 32'd9,
           32'd0, 5'd5, 5'd6, 2'b11, 2'b11, 32'd55, 32'd66);
    push("sel11_zero", 32'd0, 32'h300, 1'b1, 5'd5, 32'd9, 1);
    run_alu("sel11_zero");

    // R-type OR with imm operand
    set_in(2'b01, 3'b000, 4'b0101, 2'b00, 32'h400, 32'h40, 32'd3,
           32'h25, 5'd8, 5'd1, 2'b00, 2'b00, 32'd0, 32'd0);
    push("imm_or", 32'h65, 32'h494, 1'b0, 5'd8, 32'd3, 1);
    run_alu("imm_or");

    // R-type SLT, dest = rd
    set_in(2'b10, 3'b011, 4'b1101, 2'b00, 32'h0, 32'd5, 32'd0,
           32'h2a, 5'd2, 5'd10, 2'b00, 2'b00, 32'd0, 32'd0);
    push("imm_slt", 32'd1, 32'ha8, 1'b0, 5'd10, 32'd0, 1);
    run_alu("imm_slt");

    // negative imm on both ALU and branch adder
    set_in(2'b01, 3'b001, 4'b0001, 2'b00, 32'h1000, 32'd10, 32'd2,
           32'hffff_ffff, 5'd6, 5'd11, 2'b00, 2'b00, 32'd0, 32'd0);
    push("neg_imm", 32'd9, 32'hffc, 1'b0, 5'd6, 32'd2, 1);
    run_alu("neg_imm");

    // MUL 7*6
    set_in(2'b11, 3'b000, 4'b1000, 2'b01, 32'h500, 32'd7, 32'd6,
           32'd2, 5'd1, 5'd12, 2'b00, 2'b00, 32'd0, 32'd0);
    push("mul_7x6", 32'd42, 32'h508, 1'b0, 5'd12, 32'd6, 1);
    run_md("mul_7x6", 33, 0);

    // MUL from forwarded operands, sources scrambled mid-run
    set_in(2'b01, 3'b011, 4'b0000, 2'b01, 32'h520, 32'd1, 32'd2,
           32'd0, 5'd2, 5'd3, 2'b01, 2'b10, 32'h1_0000, 32'h3_0003);
    push("mul_fwd", 32'h0003_0000, 32'h520, 1'b0, 5'd2, 32'd0, 0);
    run_md("mul_fwd", 33, 1);

    set_in(2'b10, 3'b000, 4'b0000, 2'b01, 32'h540, 32'hffff_ffff,
           32'hffff_ffff, 32'd0, 5'd4, 5'd5, 2'b00, 2'b00, 32'd0, 32'd0);
    push("mul_ones", 32'd1, 32'h540, 1'b0, 5'd4, 32'hffff_ffff, 1);
    run_md("mul_ones", 33, 0);

    set_in(2'b01, 3'b000, 4'b0000, 2'b01, 32'h560, 32'd12345, 32'd0,
           32'd0, 5'd5, 5'd6, 2'b00, 2'b00, 32'd0, 32'd0);
    push("mul_zero", 32'd0, 32'h560, 1'b1, 5'd5, 32'd0, 1);
    run_md("mul_zero", 33, 0);

`ifdef EXECUTE_MD_DIV_EN
    set_in(2'b01, 3'b010, 4'b0000, 2'b10, 32'h600, 32'd100, 32'd7,
           32'd0, 5'd11, 5'd13, 2'b00, 2'b00, 32'd0, 32'd0);
    push("divu", 32'd14, 32'h600, 1'b0, 5'd11, 32'd7, 1);
    run_md("divu", 33, 0);
    set_in(2'b01, 3'b010, 4'b0000, 2'b11, 32'h600, 32'd100, 32'd7,
           32'd0, 5'd11, 5'd13, 2'b00, 2'b00, 32'd0, 32'd0);
    push("remu", 32'd2, 32'h600, 1'b0, 5'd11, 32'd7, 1);
    run_md("remu", 33, 0);
    set_in(2'b10, 3'b000, 4'b0000, 2'b10, 32'h610, 32'd5, 32'd0,
           32'd0, 5'd12, 5'd13, 2'b00, 2'b00, 32'd0, 32'd0);
    push("divu_by0", 32'hffff_ffff, 32'h610, 1'b0, 5'd12, 32'd0, 1);
    run_md("divu_by0", 33, 0);
    set_in(2'b10, 3'b000, 4'b0000, 2'b11, 32'h610, 32'd5, 32'd0,
           32'd0, 5'd12, 5'd13, 2'b00, 2'b00, 32'd0, 32'd0);
    push("remu_by0", 32'd5, 32'h610, 1'b0, 5'd12, 32'd0, 1);
    run_md("remu_by0", 33, 0);
`else
    set_in(2'b01, 3'b010, 4'b0000, 2'b10, 32'h600, 32'd100, 32'd7,
           32'd0, 5'd11, 5'd13, 2'b00, 2'b00, 32'd0, 32'd0);
    push("divu_off", 32'd107, 32'h600, 1'b0, 5'd11, 32'd7, 1);
    run_alu("divu_off");
    set_in(2'b10, 3'b000, 4'b0000, 2'b11, 32'h610, 32'd5, 32'd0,
           32'd0, 5'd12, 5'd13, 2'b00, 2'b00, 32'd0, 32'd0);
    push("remu_off", 32'd5, 32'h610, 1'b0, 5'd12, 32'd0, 1);
    run_alu("remu_off");
`endif

    // flush at RUN cycle 10
    set_in(2'b11, 3'b111, 4'b1000, 2'b01, 32'h900, 32'd3, 32'd3,
           32'd0, 5'd1, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < 11; i++) @(negedge clk);
    flush = 1'b1;
    step();
    bubble();
    @(negedge clk);
    chk("flush_run.busy", {31'd0, md_busy}, 0);
    chk("flush_run.wb", {30'd0, wb_ctlout}, 0);
    chk("flush_run.m", {29'd0, m_ctlout}, 0);
    step();

    // flush beats a simultaneous start
    set_in(2'b11, 3'b111, 4'b1000, 2'b01, 32'h900, 32'd3, 32'd3,
           32'd0, 5'd1, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_start.busy", {31'd0, md_busy}, 0);
    step();
    bubble();
    @(negedge clk);
    chk("flush_start.idle", {31'd0, md_busy}, 0);
    step();

    // flush on plain ALU op loads a bubble
    set_in(2'b11, 3'b101, 4'b0000, 2'b00, 32'h940, 32'd1, 32'd1,
           32'd0, 5'd1, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0);
    flush = 1'b1;
    step();
    bubble();
    @(negedge clk);
    chk("flush_alu.wb", {30'd0, wb_ctlout}, 0);
    chk("flush_alu.m", {29'd0, m_ctlout}, 0);
    step();

    // enable low holds EX/MEM
    set_in(2'b10, 3'b001, 4'b1000, 2'b00, 32'h800, 32'd3, 32'd4,
           32'd0, 5'd1, 5'd15, 2'b00, 2'b00, 32'd0, 32'd0);
    enable = 1'b0;
    step();
    @(negedge clk);
    chk("hold.wb", {30'd0, wb_ctlout}, 0);
    step();
    enable = 1'b1;
    push("hold_release", 32'd7, 32'h800, 1'b0, 5'd15, 32'd4, 1);
    run_alu("hold_release");

    // reset mid-run
    set_in(2'b01, 3'b010, 4'b0000, 2'b00, 32'h700, 32'h11, 32'h22,
           32'd1, 5'd14, 5'd3, 2'b00, 2'b00, 32'd0, 32'd0);
    push("pre_reset", 32'h33, 32'h704, 1'b0, 5'd14, 32'h22, 1);
    run_alu("pre_reset");
    set_in(2'b11, 3'b000, 4'b1000, 2'b01, 32'h500, 32'd9, 32'd9,
           32'd2, 5'd1, 5'd12, 2'b00, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_run.alu", alu_result, 0);
    chk("rst_run.add", add_result, 0);
    chk("rst_run.r2", rdata2out, 0);
    chk("rst_run.busy", {31'd0, md_busy}, 0);
    bubble();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    set_in(2'b11, 3'b000, 4'b1000, 2'b01, 32'h500, 32'd7, 32'd6,
           32'd2, 5'd1, 5'd12, 2'b00, 2'b00, 32'd0, 32'd0);
    push("mul_after_rst", 32'd42, 32'h508, 1'b0, 5'd12, 32'd6, 1);
    run_md("mul_after_rst", 33, 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/execute_md.md
EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the datapath width.
REQ-002 SHALL have parameter REGW, default 5, giving the register-index width.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1, pipeline advance from the hazard unit.
REQ-006 SHALL have port flush, input, 1, which kills the current EX instruction.
REQ-007 SHALL have ports wb_in[1:0], m_in[2:0], ex_in[3:0], all inputs: the WB, MEM and EX control fields.
REQ-008 SHALL have port md_op[1:0], input: 00 none, 01 MUL (low XLEN bits), 10 DIVU, 11 REMU.
REQ-009 SHALL have ports npc, rdata1, rdata2 and imm, all inputs of XLEN bits; imm is sign-extended.
REQ-010 SHALL have ports rt and rd, inputs of REGW bits, plus forward_a_sel[1:0] and forward_b_sel[1:0] inputs.
REQ-011 SHALL have ports wb_data and mem_alu_result, inputs of XLEN bits, as the forwarding sources.
REQ-012 SHALL have port md_busy, output, 1, the stall request to the hazard unit.
REQ-013 SHALL have registered outputs wb_ctlout[1:0], m_ctlout[2:0], add_result, zero, alu_result, rdata2out and dest_out[REGW-1:0].

Function
REQ-014 SHALL forward operands by select value: 00 selects the register value, 01 selects wb_data, 10 selects mem_alu_result, and 11 is treated as 00.
REQ-015 SHALL compute add_result as npc + (imm << 2), the ALU result from operand A and a mux of forwarded B or imm (mux select ex_in[0], ALU op ex_in[2:1] with imm[5:0]), zero = (ALU result == 0), and dest = ex_in[3] ? rd : rt.
REQ-016 SHALL run an FSM with states IDLE, RUN and DONE; the reset state is IDLE.
REQ-017 SHALL move IDLE->RUN when md_op != 0, enable = 1 and flush = 0, latching the forwarded operands and md_op at that edge.
REQ-018 SHALL iterate one bit per cycle in RUN (shift-add multiply, restoring divide) and move RUN->DONE after exactly XLEN cycles.
REQ-019 SHALL move DONE->IDLE on the next edge, loading the md result into alu_result with zero computed from it.
REQ-020 SHALL drive md_busy combinationally high in IDLE while a start condition holds, and throughout RUN; md_busy SHALL be low in DONE.
REQ-021 SHALL produce a total md latency of XLEN+2 edges from acceptance to the EX/MEM load.
REQ-022 SHALL produce, on DIVU by zero, a quotient of all ones; REMU by zero SHALL return the dividend.
REQ-023 SHALL load EX/MEM when enable = 1 and md_busy = 0, and hold EX/MEM when enable = 0.
REQ-024 SHALL load a bubble into EX/MEM when md_busy = 1: wb_ctlout and m_ctlout go to 0 and the datapath values are don't-care.
REQ-025 SHALL, on flush, force the FSM to IDLE and load a bubble; flush wins over a simultaneous start or DONE.
REQ-026 SHALL ignore changes in the forwarding inputs during RUN.

Reset
REQ-027 SHALL, while rst = 0, clear every registered output to 0 and put the FSM in IDLE with counter = 0, independent of clk.
REQ-028 SHALL abort any in-flight md operation on reset with no result written.

Configuration
REQ-029 SHALL compile the divider in when EXECUTE_MD_DIV_EN is defined, with DIVU/REMU per REQ-018 to REQ-022.
REQ-030 SHALL, when EXECUTE_MD_DIV_EN is undefined, treat md_op 10/11 as 00 (plain ALU path, no stall) and remove the divider logic.

Structure
REQ-031 SHALL place the md_op encodings, the FSM state encoding and the forward-select encodings in package execute_md_pkg.
REQ-032 SHALL implement the iterative unit as sub-module md_unit, with ports start, op, a, b, busy, done and result.
REQ-033 SHALL instantiate the existing ALU and ALU_CONTROL modules unchanged.

Verification
REQ-034 SHALL cover this case: XLEN=32, md_op=01, A=7, B=6 -> md_busy high for 33 cycles, alu_result=42 in EX/MEM, bubbles loaded during the stall.
REQ-035 SHALL cover this case: DIVU 100/7 -> result 14; REMU 100/7 -> result 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-036 SHALL cover this case: forward_a_sel=10 with mem_alu_result=9 on an ALU add with rdata2=1 -> alu_result=10, md_busy stays 0.
REQ-037 SHALL cover this case: flush asserted at RUN cycle 10 -> FSM returns to IDLE, md_busy falls, and EX/MEM gets wb_ctlout=0 and m_ctlout=0.
REQ-038 SHALL cover this case: rst low mid-RUN -> all outputs 0 immediately, and a new MUL after release completes correctly.
REQ-039 SHALL cover this case: build without EXECUTE_MD_DIV_EN, md_op=10 -> no stall, result equals the ALU result for ex_in.
